// File: rtl/enc_pkg.sv
// Shared definitions for the immediate field encoder: opcode class
// constants, the class enum, and the field-width / range-check helpers.
package enc_pkg;

    localparam int INSTR_W = 16;
    localparam int IMM_W   = 16;

    localparam logic [3:0] OP_B0 = 4'b1000;
    localparam logic [3:0] OP_B1 = 4'b1011;
    localparam logic [3:0] OP_C0 = 4'b0100;
    localparam logic [3:0] OP_C1 = 4'b0101;
    localparam logic [3:0] OP_C2 = 4'b0110;
    localparam logic [3:0] OP_D0 = 4'b1100;
    localparam logic [3:0] OP_D1 = 4'b1111;

    typedef enum logic [1:0] {
        CLS_A,
        CLS_B,
        CLS_C,
        CLS_D
    } op_class_e;

    // Classify an opcode; anything not named explicitly is class A.
    function automatic op_class_e op_class(input logic [3:0] op);
        case (op)
            OP_B0, OP_B1:        return CLS_B;
            OP_C0, OP_C1, OP_C2: return CLS_C;
            OP_D0, OP_D1:        return CLS_D;
            default:             return CLS_A;
        endcase
    endfunction

    // Width of the immediate field carried by this opcode's class.
    function automatic int unsigned field_width(input logic [3:0] op);
        case (op_class(op))
            CLS_C:   return 8;
            CLS_D:   return 12;
            default: return 4;
        endcase
    endfunction

    // A signed value fits in 'width' bits when every bit from the field's
    // sign bit upward is a copy of that sign bit.
    function automatic logic fits(input logic [IMM_W-1:0] imm, input int unsigned width);
        logic [IMM_W-1:0] upper;
        upper = $unsigned($signed(imm) >>> (width - 1));
        return (upper == '0) || (upper == '1);
    endfunction

endpackage

// File: rtl/enc_out_fifo.sv
// Small synchronous FIFO holding encoded words (instr + overflow flag).
// Head data reads as zero while empty so the outputs are clean after reset.
module enc_out_fifo
    import enc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Storage write on accepted push.
    // NOTE: storage is deliberately not reset; validity comes from count and
    // the head is masked while empty, so reset-free RAM is safe here.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/imm_field_encoder.sv
// Packs opcode, register fields and a signed immediate into a 16-bit
// instruction word, narrowing the immediate to its class field width and
// flagging values that do not fit. Output is buffered in a small FIFO.
// Optional feature: define IMM_SAT_EN to clamp out-of-range immediates to
// the field min/max instead of truncating them.
module imm_field_encoder
    import enc_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           opcode,
    input  logic [3:0]           ra,
    input  logic [3:0]           rb,
    input  logic [IMM_W-1:0]     imm,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INSTR_W-1:0]   instr,
    output logic                 imm_ovf,
    output logic [OVF_CNT_W-1:0] ovf_cnt
);

    op_class_e          cls;
    logic               fit;
    logic [11:0]        field;
    logic [INSTR_W-1:0] enc_instr;
    logic               push;
    logic               pop;
    logic               full;
    logic               empty;
    logic [INSTR_W:0]   head;

    // Encode the presented request: classify, range-check, narrow, pack.
    // NOTE: every output of this block gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        cls   = op_class(opcode);
        fit   = fits(imm, field_width(opcode));
        field = imm[11:0];
`ifdef IMM_SAT_EN
        if (!fit) begin
            case (cls)
                CLS_C:   field = {4'h0, (imm[15] ? 8'h80 : 8'h7F)};
                CLS_D:   field = imm[15] ? 12'h800 : 12'h7FF;
                default: field = {8'h00, (imm[15] ? 4'h8 : 4'h7)};
            endcase
        end
`endif
        case (cls)
            CLS_B:   enc_instr = {opcode, ra, rb, field[3:0]};
            CLS_C:   enc_instr = {opcode, ra, field[7:0]};
            CLS_D:   enc_instr = {opcode, field};
            default: enc_instr = {opcode, ra, field[3:0], rb};
        endcase
    end

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign instr     = head[INSTR_W-1:0];
    assign imm_ovf   = head[INSTR_W];

    enc_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_W + 1)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({!fit, enc_instr}),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // Saturating count of accepted requests whose immediate overflowed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (push && !fit && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + OVF_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_field_encoder.sv
// Directed self-checking bench for imm_field_encoder (default DEPTH=2,
// OVF_CNT_W=8). Expected words are hand-computed; saturating variants are
// selected when IMM_SAT_EN is defined.
module tb_imm_field_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [15:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] instr;
    logic        imm_ovf;
    logic [7:0]  ovf_cnt;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [15:0] imm;
        logic [15:0] exp_instr;
        logic        exp_ovf;
    } vec_t;

    imm_field_encoder #(.DEPTH(2), .OVF_CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .ra        (ra),
        .rb        (rb),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .imm_ovf   (imm_ovf),
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        opcode = v.op;
        ra     = v.ra;
        rb     = v.rb;
        imm    = v.imm;
    endtask

    function automatic void bump_cnt(input logic ovf);
        if (ovf && exp_cnt < 255) exp_cnt++;
    endfunction

    // Independent reference encoder using integer range arithmetic.
    function automatic void model(input logic [3:0] op, input logic [3:0] r1, input logic [3:0] r2,
                                  input logic [15:0] im, output logic [15:0] w, output logic o);
        int f, v, lo, hi, fv;
        logic [11:0] fb;
        if (op == 4'h8 || op == 4'hB)                     f = 4;
        else if (op == 4'h4 || op == 4'h5 || op == 4'h6)  f = 8;
        else if (op == 4'hC || op == 4'hF)                f = 12;
        else                                              f = 4;
        v  = int'($signed(im));
        lo = -(1 << (f - 1));
        hi = (1 << (f - 1)) - 1;
        o  = (v < lo) || (v > hi);
        fv = v;
`ifdef IMM_SAT_EN
        if (v < lo) fv = lo;
        else if (v > hi) fv = hi;
`endif
        fb = fv[11:0];
        if (f == 12)                       w = {op, fb};
        else if (f == 8)                   w = {op, r1, fb[7:0]};
        else if (op == 4'h8 || op == 4'hB) w = {op, r1, r2, fb[3:0]};
        else                               w = {op, r1, fb[3:0], r2};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_cmp++; if (instr !== 16'h0000) begin n_err++; $display("FAIL reset_instr got=%h exp=0000", instr); end
        n_cmp++; if (imm_ovf !== 1'b0) begin n_err++; $display("FAIL reset_imm_ovf got=%b exp=0", imm_ovf); end
        n_cmp++; if (ovf_cnt !== 8'h00) begin n_err++; $display("FAIL reset_ovf_cnt got=%h exp=00", ovf_cnt); end
        exp_cnt = 0;
    endtask

    task automatic test_encode();
        vec_t vecs[10];
`ifdef IMM_SAT_EN
        vecs[1] = '{4'h8, 4'h3, 4'h4, 16'h0008, 16'h8347, 1'b1};
        vecs[3] = '{4'hC, 4'h0, 4'h0, 16'h0800, 16'hC7FF, 1'b1};
        vecs[5] = '{4'hB, 4'hF, 4'h0, 16'hFFF7, 16'hBF08, 1'b1};
        vecs[7] = '{4'h5, 4'h5, 4'h0, 16'hFF7F, 16'h5580, 1'b1};
        vecs[9] = '{4'h7, 4'h1, 4'h2, 16'h0010, 16'h7172, 1'b1};
`else
        vecs[1] = '{4'h8, 4'h3, 4'h4, 16'h0008, 16'h8348, 1'b1};
        vecs[3] = '{4'hC, 4'h0, 4'h0, 16'h0800, 16'hC800, 1'b1};
        vecs[5] = '{4'hB, 4'hF, 4'h0, 16'hFFF7, 16'hBF07, 1'b1};
        vecs[7] = '{4'h5, 4'h5, 4'h0, 16'hFF7F, 16'h557F, 1'b1};
        vecs[9] = '{4'h7, 4'h1, 4'h2, 16'h0010, 16'h7102, 1'b1};
`endif
        vecs[0] = '{4'h8, 4'h3, 4'h4, 16'hFFFA, 16'h834A, 1'b0};
        vecs[2] = '{4'h4, 4'h2, 4'h9, 16'hFF80, 16'h4280, 1'b0};
        vecs[4] = '{4'h0, 4'h1, 4'h2, 16'h0005, 16'h0152, 1'b0};
        vecs[6] = '{4'h6, 4'h5, 4'h3, 16'h007F, 16'h657F, 1'b0};
        vecs[8] = '{4'hF, 4'hA, 4'hB, 16'hF800, 16'hF800, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            bump_cnt(vecs[i].exp_ovf);
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL enc%0d_valid got=%b exp=1", i, out_valid); end
            n_cmp++; if (instr !== vecs[i].exp_instr) begin n_err++; $display("FAIL enc%0d_instr got=%h exp=%h", i, instr, vecs[i].exp_instr); end
            n_cmp++; if (imm_ovf !== vecs[i].exp_ovf) begin n_err++; $display("FAIL enc%0d_ovf got=%b exp=%b", i, imm_ovf, vecs[i].exp_ovf); end
            n_cmp++; if (ovf_cnt !== 8'(exp_cnt)) begin n_err++; $display("FAIL enc%0d_cnt got=%0d exp=%0d", i, ovf_cnt, exp_cnt); end
            tick();
            n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL enc%0d_drain got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        vec_t v[3];
        v[0] = '{4'h8, 4'h3, 4'h4, 16'hFFFA, 16'h834A, 1'b0};
        v[1] = '{4'h4, 4'h2, 4'h0, 16'hFF80, 16'h4280, 1'b0};
        v[2] = '{4'h0, 4'h1, 4'h2, 16'h0005, 16'h0152, 1'b0};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(v[0]); tick();
        drive(v[1]); tick();
        drive(v[2]);
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_full_ready got=%b exp=0", in_ready); end
        repeat (2) tick();
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_still_full got=%b exp=0", in_ready); end
        n_cmp++; if (instr !== 16'h834A) begin n_err++; $display("FAIL bp_hold_instr got=%h exp=834A", instr); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold_valid got=%b exp=1", out_valid); end
        out_ready = 1'b1;
        tick();
        n_cmp++; if (instr !== 16'h4280) begin n_err++; $display("FAIL bp_second got=%h exp=4280", instr); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_freed_ready got=%b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (instr !== 16'h0152) begin n_err++; $display("FAIL bp_third got=%h exp=0152", instr); end
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_third_valid got=%b exp=1", out_valid); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        logic        o;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            opcode = 4'(i);
            ra     = 4'(i * 3);
            rb     = 4'(i * 7);
            imm    = 16'((i * 37) - 1800);
            model(opcode, ra, rb, imm, w, o);
            in_valid = 1'b1;
            tick();
            bump_cnt(o);
            n_cmp++; if (instr !== w || out_valid !== 1'b1) begin n_err++; $display("FAIL b2b%0d_instr got=%h/%b exp=%h/1", i, instr, out_valid, w); end
            n_cmp++; if (imm_ovf !== o) begin n_err++; $display("FAIL b2b%0d_ovf got=%b exp=%b", i, imm_ovf, o); end
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b%0d_ready got=%b exp=1", i, in_ready); end
        end
        in_valid = 1'b0;
        n_cmp++; if (ovf_cnt !== 8'(exp_cnt)) begin n_err++; $display("FAIL b2b_cnt got=%0d exp=%0d", ovf_cnt, exp_cnt); end
        tick();
    endtask

    task automatic test_reset_mid();
        vec_t v0, v1;
        v0 = '{4'h8, 4'h3, 4'h4, 16'h0008, 16'h0000, 1'b1};
        v1 = '{4'h4, 4'h2, 4'h0, 16'hFF80, 16'h4280, 1'b0};
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive(v0); tick();
        drive(v1); tick();
        in_valid = 1'b0;
        n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL rm_buffered got=%b/%b exp=1/0", out_valid, in_ready); end
        #2 rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid got=%b exp=0", out_valid); end
        n_cmp++; if (ovf_cnt !== 8'h00) begin n_err++; $display("FAIL rm_cnt got=%h exp=00", ovf_cnt); end
        n_cmp++; if (instr !== 16'h0000) begin n_err++; $display("FAIL rm_instr got=%h exp=0000", instr); end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready got=%b exp=1", in_ready); end
        opcode = 4'h0; ra = 4'h1; rb = 4'h2; imm = 16'h0005;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++; if (instr !== 16'h0152 || out_valid !== 1'b1) begin n_err++; $display("FAIL rm_resume got=%h/%b exp=0152/1", instr, out_valid); end
        tick();
    endtask

    task automatic test_ovf_sat();
        out_ready = 1'b1;
        opcode = 4'h8; ra = 4'h1; rb = 4'h1; imm = 16'h0100;
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            tick();
            bump_cnt(1'b1);
            n_cmp++; if (ovf_cnt !== 8'(exp_cnt)) begin n_err++; $display("FAIL sat%0d_cnt got=%0d exp=%0d", i, ovf_cnt, exp_cnt); end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (ovf_cnt !== 8'hFF) begin n_err++; $display("FAIL sat_final got=%h exp=FF", ovf_cnt); end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = '0;
        ra        = '0;
        rb        = '0;
        imm       = '0;
        test_reset();
        test_encode();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_ovf_sat();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
